demux8_dispatch: RTL and testbench

DEMUX8_DISPATCH -- requirements
Module: demux8_dispatch

---
 rtl/demux8_dispatch.sv | 104 ++++++++++
 tb/tb_demux8_dispatch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux8_dispatch.sv
// One-word holding demux: accepts a word, steers it to one of eight channels
// by fixed destination or round-robin, and reports stall and delivery counts.
module demux8_dispatch #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_dest,
    input  logic             rr_mode,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic             busy,
    output logic [7:0]       stall_cnt,
    output logic [15:0]      word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [2:0]         sel_q;
    logic [2:0]         rr_q;
    logic [7:0]         stall_q;
    logic [15:0]        wcnt_q;

    logic               sel_rdy;
    logic               accept;
    logic               deliver;
    logic [2:0]         dest;

    assign sel_rdy = out_ready[sel_q];
    assign dest    = rr_mode ? rr_q : in_dest;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b1;
        accept    = 1'b0;
        deliver   = 1'b0;
        out_valid = 8'h00;
        out_data  = '0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept)
                    state_d = HOLD;
            end
            HOLD: begin
                // a free slot only opens when the held word leaves this edge
                in_ready  = sel_rdy;
                accept    = in_valid & sel_rdy;
                deliver   = sel_rdy;
                out_valid = 8'h01 << sel_q;
                out_data  = data_q;
                busy      = 1'b1;
                if (deliver && !accept)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= 3'd0;
            rr_q    <= 3'd0;
            stall_q <= 8'd0;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
                sel_q  <= dest;
                if (rr_mode)
                    rr_q <= rr_q + 3'd1;
            end
            if (accept)
                stall_q <= 8'd0;
            else if (state_q == HOLD && !sel_rdy && stall_q != 8'hFF)
                stall_q <= stall_q + 8'd1;
            if (deliver)
                wcnt_q <= wcnt_q + 16'd1;
        end
    end

    assign sel       = sel_q;
    assign stall_cnt = stall_q;
    assign word_cnt  = wcnt_q;

endmodule

// File: tb/tb_demux8_dispatch.sv
// Directed vector bench for demux8_dispatch: table of per-edge expectations
// plus hand-written backpressure and asynchronous reset sequences.
module tb_demux8_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_dest;
    logic        rr_mode;
    logic [2:0]  sel;
    logic [15:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic        busy;
    logic [7:0]  stall_cnt;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    demux8_dispatch #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .rr_mode   (rr_mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic [2:0]  dest;
        logic        rr;
        logic [7:0]  ordy;
        logic [7:0]  e_ov;
        logic [2:0]  e_sel;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_ir;
        logic [15:0] e_wc;
        logic [7:0]  e_st;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic iv, input logic [15:0] d, input logic [2:0] dest,
        input logic rr, input logic [7:0] ordy, input logic [7:0] e_ov,
        input logic [2:0] e_sel, input logic [15:0] e_data,
        input logic e_busy, input logic e_ir, input logic [15:0] e_wc,
        input logic [7:0] e_st);
        vec_t v;
        v.iv = iv; v.d = d; v.dest = dest; v.rr = rr; v.ordy = ordy;
        v.e_ov = e_ov; v.e_sel = e_sel; v.e_data = e_data;
        v.e_busy = e_busy; v.e_ir = e_ir; v.e_wc = e_wc; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] d,
                         input logic [2:0] dest, input logic rr,
                         input logic [7:0] ordy);
        in_valid  = iv;
        in_data   = d;
        in_dest   = dest;
        rr_mode   = rr;
        out_ready = ordy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_ir;
        int bad_st;
        int exp_st;

        drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h00);
        rst = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_word_cnt", 32'(word_cnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // fixed destination
        vq.push_back(mk(1, 16'hBEEF, 5, 0, 8'hFF, 8'h20, 5, 16'hBEEF, 1, 1, 0, 0));
        vq.push_back(mk(0, 16'h0000, 0, 0, 8'hFF, 8'h00, 5, 16'h0000, 0, 1, 1, 0));
        // round-robin, ten back-to-back words
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(1, 16'(16'h0100 + i), 3'd7, 1, 8'hFF,
                            8'(8'h01 << (i % 8)), 3'(i % 8),
                            16'(16'h0100 + i), 1, 1, 16'(1 + i), 0));
        vq.push_back(mk(0, 16'h0000, 0, 1, 8'hFF, 8'h00, 1, 16'h0000, 0, 1, 11, 0));
        // non-selected channels ready only
        vq.push_back(mk(1, 16'h0333, 3, 0, 8'hF7, 8'h08, 3, 16'h0333, 1, 0, 11, 0));
        vq.push_back(mk(1, 16'h9999, 4, 0, 8'hF7, 8'h08, 3, 16'h0333, 1, 0, 11, 1));
        vq.push_back(mk(1, 16'h9999, 4, 1, 8'hF7, 8'h08, 3, 16'h0333, 1, 0, 11, 2));
        vq.push_back(mk(0, 16'h0000, 0, 0, 8'h08, 8'h00, 3, 16'h0000, 0, 1, 12, 2));
        // simultaneous deliver and accept
        vq.push_back(mk(1, 16'h0111, 1, 0, 8'h00, 8'h02, 1, 16'h0111, 1, 0, 12, 0));
        vq.push_back(mk(1, 16'h1234, 6, 0, 8'h02, 8'h40, 6, 16'h1234, 1, 0, 13, 0));
        vq.push_back(mk(0, 16'h0000, 0, 0, 8'h40, 8'h00, 6, 16'h0000, 0, 1, 14, 0));
        // rr pointer resumes at 2 after the ten-word run
        vq.push_back(mk(1, 16'h0222, 7, 1, 8'hFF, 8'h04, 2, 16'h0222, 1, 1, 14, 0));
        vq.push_back(mk(0, 16'h0000, 0, 0, 8'hFF, 8'h00, 2, 16'h0000, 0, 1, 15, 0));

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].iv, vq[k].d, vq[k].dest, vq[k].rr, vq[k].ordy);
            step();
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vq[k].e_ov));
            chk($sformatf("v%0d_sel", k), 32'(sel), 32'(vq[k].e_sel));
            chk($sformatf("v%0d_out_data", k), 32'(out_data), 32'(vq[k].e_data));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vq[k].e_busy));
            chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vq[k].e_ir));
            chk($sformatf("v%0d_word_cnt", k), 32'(word_cnt), 32'(vq[k].e_wc));
            chk($sformatf("v%0d_stall_cnt", k), 32'(stall_cnt), 32'(vq[k].e_st));
        end

        // backpressure on channel 2 for 300 cycles
        @(negedge clk);
        drive(1'b1, 16'h0ABC, 3'd2, 1'b0, 8'hFB);
        step();
        chk("bp_accept_sel", 32'(sel), 32'h2);
        @(negedge clk);
        drive(1'b1, 16'hDEAD, 3'd4, 1'b0, 8'hFB);
        bad_ir = 0;
        bad_st = 0;
        for (int n = 1; n <= 300; n++) begin
            step();
            exp_st = (n > 255) ? 255 : n;
            if (in_ready !== 1'b0) bad_ir++;
            if (stall_cnt !== 8'(exp_st)) bad_st++;
        end
        chk("bp_in_ready_low_cycles", 32'(bad_ir), 32'h0);
        chk("bp_stall_track_cycles", 32'(bad_st), 32'h0);
        chk("bp_stall_sat", 32'(stall_cnt), 32'd255);
        chk("bp_data_kept", 32'(out_data), 32'h0ABC);
        chk("bp_word_cnt_hold", 32'(word_cnt), 32'd15);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h04);
        step();
        chk("bp_deliver_word_cnt", 32'(word_cnt), 32'd16);
        chk("bp_deliver_busy", 32'(busy), 32'h0);
        chk("bp_idle_stall_hold", 32'(stall_cnt), 32'd255);

        // asynchronous reset while holding a word
        @(negedge clk);
        drive(1'b1, 16'h5555, 3'd5, 1'b0, 8'h00);
        step();
        chk("ar_hold_busy", 32'(busy), 32'h1);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'h00);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_word_cnt", 32'(word_cnt), 32'h0);
        chk("ar_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("ar_out_data", 32'(out_data), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_post_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 16'h7777, 3'd6, 1'b1, 8'h00);
        step();
        chk("ar_rr_first_sel", 32'(sel), 32'h0);
        chk("ar_rr_first_valid", 32'(out_valid), 32'h01);
        chk("ar_rr_word_cnt", 32'(word_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
